// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: operation
// encoding and default geometry.
package cla_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_ADDC = 2'd2
  } op_e;

  localparam int CLA_WIDTH  = 16;
  localparam int CLA_GROUP  = 4;
  localparam int CLA_STAGES = 2;

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead group: flat sum-of-products carries from
// the group carry-in, plus group generate/propagate for the next level.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             c_in,
  output logic [GROUP-1:0] sum,
  output logic             g_out,
  output logic             p_out
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] x;
  logic [GROUP-1:0] c;

  assign g = a & b;
  assign p = a | b;
  assign x = a ^ b;

  // Mask with bits [lo, hi) set; used to AND together a run of propagates.
  function automatic logic [GROUP-1:0] span(input int lo, input int hi);
    logic [GROUP-1:0] ones;
    ones = '1;
    return (ones << lo) & ~(ones << hi);
  endfunction

  always_comb begin
    c = '0;
    for (int i = 0; i < GROUP; i++) begin
      c[i] = c_in & (&(p | ~span(0, i)));
      for (int j = 0; j < i; j++) begin
        c[i] = c[i] | (g[j] & (&(p | ~span(j + 1, i))));
      end
    end
  end

  always_comb begin
    g_out = 1'b0;
    for (int j = 0; j < GROUP; j++) begin
      g_out = g_out | (g[j] & (&(p | ~span(j + 1, GROUP))));
    end
  end

  assign p_out = &p;
  assign sum   = x ^ c;

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined two-level carry-lookahead adder/subtractor with valid/ready
// flow control; one WIDTH/STAGES-bit slice is resolved per pipeline stage.
module pipe_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = CLA_WIDTH,
  parameter int GROUP  = CLA_GROUP,
  parameter int STAGES = CLA_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int NGRP  = SLICE / GROUP;
  localparam int LAST  = STAGES - 1;

  if (STAGES < 1 || STAGES > 4 || (WIDTH % (GROUP * STAGES)) != 0) begin : g_param_check
    $error("pipe_cla_adder: WIDTH must be a multiple of GROUP*STAGES and STAGES in 1..4");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction is a + ~b + 1; the reserved encoding falls through to ADD.
  always_comb begin
    b_eff = b;
    c_eff = 1'b0;
    case (op)
      OP_SUB: begin
        b_eff = ~b;
        c_eff = 1'b1;
      end
      OP_ADDC: c_eff = cin;
      default: ;
    endcase
  end

  function automatic logic [NGRP-1:0] gspan(input int lo, input int hi);
    logic [NGRP-1:0] ones;
    ones = '1;
    return (ones << lo) & ~(ones << hi);
  endfunction

  genvar gi, gj;

  // Combinational slice logic; stage gi sees operand bits from slice gi upward.
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int REMW = WIDTH - gi * SLICE;
    logic [REMW-1:0]  a_rem;
    logic [REMW-1:0]  b_rem;
    logic             c_in;
    logic [NGRP:0]    c_grp;
    logic [NGRP-1:0]  g_grp;
    logic [NGRP-1:0]  p_grp;
    logic [SLICE-1:0] s_slice;

    if (gi == 0) begin : g_src
      assign a_rem = a;
      assign b_rem = b_eff;
      assign c_in  = c_eff;
    end else begin : g_src
      assign a_rem = g_reg[gi].a_reg;
      assign b_rem = g_reg[gi].b_reg;
      assign c_in  = g_reg[gi].c_reg;
    end

    for (gj = 0; gj < NGRP; gj++) begin : g_grp_inst
      cla_group #(.GROUP(GROUP)) u_grp (
        .a     (a_rem[gj*GROUP +: GROUP]),
        .b     (b_rem[gj*GROUP +: GROUP]),
        .c_in  (c_grp[gj]),
        .sum   (s_slice[gj*GROUP +: GROUP]),
        .g_out (g_grp[gj]),
        .p_out (p_grp[gj])
      );
    end

    // Second-level lookahead across the groups of this slice.
    always_comb begin
      c_grp    = '0;
      c_grp[0] = c_in;
      for (int i = 1; i <= NGRP; i++) begin
        c_grp[i] = c_in & (&(p_grp | ~gspan(0, i)));
        for (int j = 0; j < i; j++) begin
          c_grp[i] = c_grp[i] | (g_grp[j] & (&(p_grp | ~gspan(j + 1, i))));
        end
      end
    end
  end

  // Inter-stage registers: unresolved upper operands, resolved lower sum, slice carry.
  for (gi = 1; gi < STAGES; gi++) begin : g_reg
    localparam int REMW = WIDTH - gi * SLICE;
    logic [REMW-1:0]     a_reg;
    logic [REMW-1:0]     b_reg;
    logic [gi*SLICE-1:0] s_reg;
    logic [gi*SLICE-1:0] s_next;
    logic                c_reg;
    logic                v_reg;
    logic                v_next;

    if (gi == 1) begin : g_lo
      assign s_next = g_stage[0].s_slice;
      assign v_next = in_valid;
    end else begin : g_lo
      assign s_next = {g_stage[gi-1].s_slice, g_reg[gi-1].s_reg};
      assign v_next = g_reg[gi-1].v_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_reg <= 1'b0;
        c_reg <= 1'b0;
        a_reg <= '0;
        b_reg <= '0;
        s_reg <= '0;
      end else if (adv) begin
        v_reg <= v_next;
        c_reg <= g_stage[gi-1].c_grp[NGRP];
        a_reg <= g_stage[gi-1].a_rem[REMW+SLICE-1:SLICE];
        b_reg <= g_stage[gi-1].b_rem[REMW+SLICE-1:SLICE];
        s_reg <= s_next;
      end
    end
  end

  logic [WIDTH-1:0] sum_next;
  logic             v_last;
  logic             cout_next;
  logic             c_msb;

  if (STAGES == 1) begin : g_out
    assign sum_next = g_stage[0].s_slice;
    assign v_last   = in_valid;
  end else begin : g_out
    assign sum_next = {g_stage[LAST].s_slice, g_reg[LAST].s_reg};
    assign v_last   = g_reg[LAST].v_reg;
  end

  // Carry into the MSB recovered from its half-sum and result bit.
  assign cout_next = g_stage[LAST].c_grp[NGRP];
  assign c_msb     = g_stage[LAST].a_rem[SLICE-1] ^ g_stage[LAST].b_rem[SLICE-1]
                   ^ sum_next[WIDTH-1];

  logic             out_valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             zero_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      zero_reg      <= 1'b0;
    end else if (adv) begin
      out_valid_reg <= v_last;
      sum_reg       <= sum_next;
      cout_reg      <= cout_next;
      ovf_reg       <= c_msb ^ cout_next;
      zero_reg      <= ~|sum_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;
  assign zero      = zero_reg;

endmodule
